// File: rtl/jtag_sync_tx_controller.sv
// Source-side sequencer for a multi-bit toggle synchronizer: arbitrates two producers,
// holds the granted word stable, toggles sync_req after a settle window and waits for the ack toggle.
module jtag_sync_tx_controller #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             ack_sync,
    input  logic             clear_err,
    output logic [WIDTH-1:0] sync_data,
    output logic             sync_req,
    output logic             grant_id,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sync_data;
    logic             r_sync_req;
    logic             r_grant_id;
    logic             r_last_grant;
    logic             r_done;
    logic             r_timeout_err;
    logic [SCW-1:0]   r_settle_cnt;
    logic [TW-1:0]    r_wait_cnt;

    logic             w_enable;
    logic             w_grant;
    logic             w_accept;
    logic             w_ack_match;
    logic             w_set_err;

    // Accepting while an ack is still in flight would pair a new word with a stale ack.
    assign w_ack_match = (ack_sync == r_sync_req);
    assign w_enable    = n_reset && (r_state == ST_IDLE) && w_ack_match;
    assign w_grant     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = w_enable && (req0_valid || req1_valid);
    assign w_set_err   = (r_state == ST_WAIT_ACK) && !w_ack_match &&
                         (r_wait_cnt == TW'(TIMEOUT - 1));

    assign req0_ready  = w_enable && !w_grant && req0_valid;
    assign req1_ready  = w_enable &&  w_grant && req1_valid;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= ST_IDLE;
            r_sync_data   <= '0;
            r_sync_req    <= 1'b0;
            r_grant_id    <= 1'b0;
            r_last_grant  <= 1'b1;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_settle_cnt  <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_done <= 1'b0;

            // A set on the same edge as a clear wins.
            if (w_set_err)
                r_timeout_err <= 1'b1;
            else if (clear_err)
                r_timeout_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sync_data  <= w_grant ? req1_data : req0_data;
                        r_grant_id   <= w_grant;
                        r_last_grant <= w_grant;
                        r_settle_cnt <= '0;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == SCW'(SETTLE_CYCLES - 1)) begin
                        r_sync_req <= ~r_sync_req;
                        r_wait_cnt <= '0;
                        r_state    <= ST_WAIT_ACK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SCW'(1);
                    end
                end
                ST_WAIT_ACK: begin
                    // No abort on timeout: the flag is raised but we keep waiting.
                    if (w_ack_match) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (r_wait_cnt != TW'(TIMEOUT)) begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sync_data   = r_sync_data;
    assign sync_req    = r_sync_req;
    assign grant_id    = r_grant_id;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_jtag_sync_tx_controller.sv
// Directed bench for jtag_sync_tx_controller: reset, single transfer, round-robin,
// timeout/clear, stale-ack guard and reset mid-transfer, with hand-computed expectations.
module tb_jtag_sync_tx_controller;

    localparam int WIDTH = 10;

    logic             clock;
    logic             n_reset;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             ack_sync;
    logic             clear_err;
    logic [WIDTH-1:0] sync_data;
    logic             sync_req;
    logic             grant_id;
    logic             busy;
    logic             done;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;

    jtag_sync_tx_controller #(
        .WIDTH(WIDTH),
        .SETTLE_CYCLES(2),
        .TIMEOUT(4)
    ) dut (
        .clock(clock),
        .n_reset(n_reset),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .ack_sync(ack_sync),
        .clear_err(clear_err),
        .sync_data(sync_data),
        .sync_req(sync_req),
        .grant_id(grant_id),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_reset    = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 10'h3FF;
        req1_valid = 1'b0;
        req1_data  = '0;
        ack_sync   = 1'b0;
        clear_err  = 1'b0;
        #12;

        // Reset state, readies held low even with a valid requester.
        chk("rst_sync_data", 32'(sync_data), 32'h0);
        chk("rst_sync_req", 32'(sync_req), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_req0_ready", 32'(req0_ready), 32'h0);

        // Single req0 transfer.
        n_reset = 1'b1;
        #1;
        chk("t1_req0_ready_pre", 32'(req0_ready), 32'h1);
        tick();                                         // E0
        chk("t1_req0_ready_post", 32'(req0_ready), 32'h0);
        req0_valid = 1'b0;
        chk("t1_sync_data", 32'(sync_data), 32'h3FF);
        chk("t1_busy_e0", 32'(busy), 32'h1);
        chk("t1_sync_req_e0", 32'(sync_req), 32'h0);
        tick();                                         // E1
        chk("t1_sync_req_e1", 32'(sync_req), 32'h0);
        tick();                                         // E2
        chk("t1_sync_req_e2", 32'(sync_req), 32'h1);
        tick();                                         // E3
        tick();                                         // E4
        chk("t1_done_e4", 32'(done), 32'h0);
        ack_sync = 1'b1;
        tick();                                         // E5
        chk("t1_done_e5", 32'(done), 32'h1);
        chk("t1_busy_e5", 32'(busy), 32'h0);
        tick();
        chk("t1_done_clear", 32'(done), 32'h0);

        // Fresh reset so requester 0 wins the first tie again.
        n_reset  = 1'b0;
        ack_sync = 1'b0;
        #2;
        n_reset  = 1'b1;

        // Round-robin with both requesters valid.
        req0_valid = 1'b1;
        req0_data  = 10'h001;
        req1_valid = 1'b1;
        req1_data  = 10'h002;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic g;
            logic exp_req;
            g       = logic'(k % 2);
            exp_req = logic'((k + 1) % 2);
            chk($sformatf("rr%0d_req0_ready", k), 32'(req0_ready), 32'(!g));
            chk($sformatf("rr%0d_req1_ready", k), 32'(req1_ready), 32'(g));
            tick();                                     // accept
            chk($sformatf("rr%0d_grant_id", k), 32'(grant_id), 32'(g));
            chk($sformatf("rr%0d_sync_data", k), 32'(sync_data), g ? 32'h002 : 32'h001);
            tick();
            tick();                                     // toggle edge
            chk($sformatf("rr%0d_sync_req", k), 32'(sync_req), 32'(exp_req));
            tick();
            tick();
            ack_sync = exp_req;
            tick();                                     // ack sampled 3 edges after toggle
            chk($sformatf("rr%0d_done", k), 32'(done), 32'h1);
            chk($sformatf("rr%0d_busy", k), 32'(busy), 32'h0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_sync_req_final", 32'(sync_req), 32'h0);

        // Timeout with ack withheld.
        req0_valid = 1'b1;
        req0_data  = 10'h0AA;
        tick();                                         // E0
        req0_valid = 1'b0;
        tick();                                         // E1
        tick();                                         // E2: enter WAIT_ACK
        chk("to_sync_req", 32'(sync_req), 32'h1);
        tick();
        tick();
        tick();                                         // E5
        chk("to_err_before", 32'(timeout_err), 32'h0);
        tick();                                         // E6
        chk("to_err_set", 32'(timeout_err), 32'h1);
        chk("to_busy_set", 32'(busy), 32'h1);
        tick();
        chk("to_busy_wait", 32'(busy), 32'h1);
        ack_sync = 1'b1;
        tick();
        chk("to_done", 32'(done), 32'h1);
        chk("to_err_sticky", 32'(timeout_err), 32'h1);
        chk("to_busy_after", 32'(busy), 32'h0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("to_err_cleared", 32'(timeout_err), 32'h0);

        // Clear on the same edge the flag sets: set wins.
        req0_valid = 1'b1;
        req0_data  = 10'h055;
        tick();                                         // E0
        req0_valid = 1'b0;
        tick();
        tick();                                         // E2: sync_req -> 0
        chk("tc_sync_req", 32'(sync_req), 32'h0);
        tick();
        tick();
        tick();                                         // E5
        clear_err = 1'b1;
        tick();                                         // E6
        clear_err = 1'b0;
        chk("tc_set_wins", 32'(timeout_err), 32'h1);
        ack_sync = 1'b0;
        tick();
        chk("tc_done", 32'(done), 32'h1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("tc_err_cleared", 32'(timeout_err), 32'h0);

        // Stale ack blocks acceptance.
        ack_sync   = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 10'h3C3;
        #1;
        chk("st_ready_blocked0", 32'(req1_ready), 32'h0);
        tick();
        chk("st_ready_blocked1", 32'(req1_ready), 32'h0);
        chk("st_busy_blocked", 32'(busy), 32'h0);
        tick();
        chk("st_ready_blocked2", 32'(req1_ready), 32'h0);
        ack_sync = 1'b0;
        #1;
        chk("st_ready_open", 32'(req1_ready), 32'h1);
        tick();                                         // E0
        req1_valid = 1'b0;
        chk("st_grant_id", 32'(grant_id), 32'h1);
        chk("st_sync_data", 32'(sync_data), 32'h3C3);
        tick();
        tick();                                         // E2: sync_req -> 1
        ack_sync = 1'b1;
        tick();
        chk("st_done", 32'(done), 32'h1);

        // Reset during SETTLE drops the transfer.
        req0_valid = 1'b1;
        req0_data  = 10'h1FF;
        tick();                                         // E0
        req0_valid = 1'b0;
        chk("rm_sync_data_pre", 32'(sync_data), 32'h1FF);
        chk("rm_busy_pre", 32'(busy), 32'h1);
        #2;
        n_reset  = 1'b0;
        ack_sync = 1'b0;
        #1;
        chk("rm_sync_data", 32'(sync_data), 32'h0);
        chk("rm_sync_req", 32'(sync_req), 32'h0);
        chk("rm_busy", 32'(busy), 32'h0);
        tick();
        n_reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rm_no_done%0d", k), 32'(done), 32'h0);
            chk($sformatf("rm_idle%0d", k), 32'(busy), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
